// File: rtl/ball_engine.sv
// Per-frame ball motion sequencer: predict, wall bounce, shared paddle/goal overlap tests, atomic commit.
// Build option: define BALL_SPEEDUP_EN to raise speed by one on each paddle hit, up to MAX_SPEED.
module ball_engine #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BALL_SIZE = 8,
  parameter int PADDLE_W  = 8,
  parameter int PADDLE_H  = 64,
  parameter int LPAD_X    = 16,
  parameter int RPAD_X    = 616,
  parameter int BALL_X0   = 316,
  parameter int BALL_Y0   = 236,
  parameter int SPEED     = 2,
  parameter int MAX_SPEED = 6
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic [8:0] LPadY,
  input  logic [8:0] RPadY,
  output logic [9:0] BallX,
  output logic [8:0] BallY,
  output logic       dir_x,
  output logic       dir_y,
  output logic       busy,
  output logic       update_done,
  output logic       score_l,
  output logic       score_r,
  output logic       overrun
);

  typedef enum logic [2:0] {HOLD, IDLE, PREDICT, TEST_L, TEST_R, GOAL} state_t;

  localparam logic [10:0] BS         = 11'(BALL_SIZE);
  localparam logic [10:0] PW         = 11'(PADDLE_W);
  localparam logic [10:0] PH         = 11'(PADDLE_H);
  localparam logic [10:0] LX         = 11'(LPAD_X);
  localparam logic [10:0] RX         = 11'(RPAD_X);
  localparam logic [10:0] X_LIMIT    = 11'(SCREEN_W - 1);
  localparam logic [10:0] Y_LIMIT    = 11'(SCREEN_H - 1);
  localparam logic [10:0] Y_FLOOR    = 11'(SCREEN_H - 1 - BALL_SIZE);
  localparam logic [10:0] L_BOUNCE_X = 11'(LPAD_X + PADDLE_W + 1);
  localparam logic [10:0] R_BOUNCE_X = 11'(RPAD_X - BALL_SIZE - 1);
  localparam logic [9:0]  X0         = 10'(BALL_X0);
  localparam logic [8:0]  Y0         = 9'(BALL_Y0);
  localparam logic [2:0]  SPD0       = 3'(SPEED);
`ifdef BALL_SPEEDUP_EN
  localparam logic [2:0]  SPD_MAX    = 3'(MAX_SPEED);
`endif

  state_t      state_reg, state_next;
  logic [9:0]  ball_x_reg, ball_x_next;
  logic [8:0]  ball_y_reg, ball_y_next;
  logic        dir_x_reg, dir_x_next;
  logic        dir_y_reg, dir_y_next;
  logic [2:0]  speed_reg, speed_next;
  logic [10:0] nx_reg, nx_next;
  logic [10:0] ny_reg, ny_next;
  logic        ndx_reg, ndx_next;
  logic        ndy_reg, ndy_next;
  logic        done_reg, done_next;
  logic        score_l_reg, score_l_next;
  logic        score_r_reg, score_r_next;
  logic        overrun_reg, overrun_next;

  logic        busy_int;
  logic [10:0] bx11, by11, spd11;
  logic [10:0] px, py;
  logic        overlap;

  assign busy_int = (state_reg == PREDICT) || (state_reg == TEST_L) ||
                    (state_reg == TEST_R)  || (state_reg == GOAL);
  assign bx11  = {1'b0, ball_x_reg};
  assign by11  = {2'b0, ball_y_reg};
  assign spd11 = {8'b0, speed_reg};

  // One comparator serves both paddles; the paddle is selected by the test state.
  always_comb begin
    px = RX;
    py = {2'b0, RPadY};
    if (state_reg == TEST_L) begin
      px = LX;
      py = {2'b0, LPadY};
    end
    overlap = (px <= nx_reg + BS) && (nx_reg <= px + PW) &&
              (py <= ny_reg + BS) && (ny_reg <= py + PH);
  end

  always_comb begin
    state_next   = state_reg;
    ball_x_next  = ball_x_reg;
    ball_y_next  = ball_y_reg;
    dir_x_next   = dir_x_reg;
    dir_y_next   = dir_y_reg;
    speed_next   = speed_reg;
    nx_next      = nx_reg;
    ny_next      = ny_reg;
    ndx_next     = ndx_reg;
    ndy_next     = ndy_reg;
    done_next    = 1'b0;
    score_l_next = 1'b0;
    score_r_next = 1'b0;
    overrun_next = overrun_reg;

    if (frame_tick && busy_int) overrun_next = 1'b1;

    case (state_reg)
      HOLD: begin
        if (serve) begin
          state_next   = IDLE;
          overrun_next = 1'b0;
          speed_next   = SPD0;
        end
      end
      IDLE: begin
        if (frame_tick) state_next = PREDICT;
      end
      PREDICT: begin
        ndx_next = dir_x_reg;
        ndy_next = dir_y_reg;
        if (dir_x_reg)         nx_next = bx11 + spd11;
        else if (bx11 < spd11) nx_next = 11'd0;
        else                   nx_next = bx11 - spd11;
        if (!dir_y_reg) begin
          if (by11 < spd11) begin
            ny_next  = 11'd0;
            ndy_next = 1'b1;
          end else begin
            ny_next = by11 - spd11;
          end
        end else if (by11 + spd11 + BS > Y_LIMIT) begin
          ny_next  = Y_FLOOR;
          ndy_next = 1'b0;
        end else begin
          ny_next = by11 + spd11;
        end
        state_next = TEST_L;
      end
      TEST_L: begin
        if (!ndx_reg && overlap) begin
          nx_next  = L_BOUNCE_X;
          ndx_next = 1'b1;
`ifdef BALL_SPEEDUP_EN
          if (speed_reg < SPD_MAX) speed_next = speed_reg + 3'd1;
`endif
        end
        state_next = TEST_R;
      end
      TEST_R: begin
        if (ndx_reg && overlap) begin
          nx_next  = R_BOUNCE_X;
          ndx_next = 1'b0;
`ifdef BALL_SPEEDUP_EN
          if (speed_reg < SPD_MAX) speed_next = speed_reg + 3'd1;
`endif
        end
        state_next = GOAL;
      end
      GOAL: begin
        done_next  = 1'b1;
        dir_y_next = ndy_reg;
        if (!ndx_reg && nx_reg == 11'd0) begin
          score_r_next = 1'b1;
          ball_x_next  = X0;
          ball_y_next  = Y0;
          dir_x_next   = 1'b0;
          state_next   = HOLD;
        end else if (ndx_reg && (nx_reg + BS > X_LIMIT)) begin
          score_l_next = 1'b1;
          ball_x_next  = X0;
          ball_y_next  = Y0;
          dir_x_next   = 1'b1;
          state_next   = HOLD;
        end else begin
          ball_x_next = nx_reg[9:0];
          ball_y_next = ny_reg[8:0];
          dir_x_next  = ndx_reg;
          state_next  = IDLE;
        end
      end
      default: state_next = HOLD;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= HOLD;
      ball_x_reg  <= X0;
      ball_y_reg  <= Y0;
      dir_x_reg   <= 1'b1;
      dir_y_reg   <= 1'b1;
      speed_reg   <= SPD0;
      nx_reg      <= 11'd0;
      ny_reg      <= 11'd0;
      ndx_reg     <= 1'b1;
      ndy_reg     <= 1'b1;
      done_reg    <= 1'b0;
      score_l_reg <= 1'b0;
      score_r_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ball_x_reg  <= ball_x_next;
      ball_y_reg  <= ball_y_next;
      dir_x_reg   <= dir_x_next;
      dir_y_reg   <= dir_y_next;
      speed_reg   <= speed_next;
      nx_reg      <= nx_next;
      ny_reg      <= ny_next;
      ndx_reg     <= ndx_next;
      ndy_reg     <= ndy_next;
      done_reg    <= done_next;
      score_l_reg <= score_l_next;
      score_r_reg <= score_r_next;
      overrun_reg <= overrun_next;
    end
  end

  assign BallX       = ball_x_reg;
  assign BallY       = ball_y_reg;
  assign dir_x       = dir_x_reg;
  assign dir_y       = dir_y_reg;
  assign busy        = busy_int;
  assign update_done = done_reg;
  assign score_l     = score_l_reg;
  assign score_r     = score_r_reg;
  assign overrun     = overrun_reg;

endmodule

// File: tb/tb_ball_engine.sv
// Randomized bench for ball_engine: paddles track or miss the ball, a frame-level model predicts every commit.
module tb_ball_engine;

  logic       sys_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       serve = 1'b0;
  logic [8:0] LPadY = 9'd0;
  logic [8:0] RPadY = 9'd0;
  logic [9:0] BallX;
  logic [8:0] BallY;
  logic       dir_x, dir_y, busy, update_done, score_l, score_r, overrun;

  int vectors = 0;
  int miscompares = 0;
  int frames = 0;

  // frame-level model of the ball
  int m_x, m_y, m_dx, m_dy, m_spd, m_ovr, m_hold;
  int e_sl, e_sr;

  always #5 sys_clk = ~sys_clk;

  ball_engine dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .frame_tick(frame_tick), .serve(serve),
    .LPadY(LPadY), .RPadY(RPadY), .BallX(BallX), .BallY(BallY),
    .dir_x(dir_x), .dir_y(dir_y), .busy(busy), .update_done(update_done),
    .score_l(score_l), .score_r(score_r), .overrun(overrun)
  );

  task automatic check_val(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = 316; m_y = 236; m_dx = 1; m_dy = 1; m_spd = 2; m_ovr = 0; m_hold = 1;
  endtask

  function automatic bit boxes_touch(input int px, input int py, input int bx, input int by);
    return (px <= bx + 8) && (bx <= px + 8) && (py <= by + 8) && (by <= py + 64);
  endfunction

  task automatic bump_speed();
`ifdef BALL_SPEEDUP_EN
    if (m_spd < 6) m_spd++;
`endif
  endtask

  task automatic model_frame(input int lp, input int rp);
    int nx, ny, ndy;
    e_sl = 0; e_sr = 0;
    if (m_dx != 0) nx = m_x + m_spd;
    else nx = (m_x < m_spd) ? 0 : m_x - m_spd;
    ndy = m_dy;
    if (m_dy == 0) begin
      if (m_y < m_spd) begin ny = 0; ndy = 1; end
      else ny = m_y - m_spd;
    end else if (m_y + m_spd + 8 > 479) begin
      ny = 471; ndy = 0;
    end else begin
      ny = m_y + m_spd;
    end
    if (m_dx == 0 && boxes_touch(16, lp, nx, ny)) begin nx = 25; m_dx = 1; bump_speed(); end
    if (m_dx == 1 && boxes_touch(616, rp, nx, ny)) begin nx = 607; m_dx = 0; bump_speed(); end
    m_dy = ndy;
    if (m_dx == 0 && nx == 0) begin
      e_sr = 1; m_x = 316; m_y = 236; m_hold = 1;
    end else if (m_dx == 1 && nx + 8 > 639) begin
      e_sl = 1; m_x = 316; m_y = 236; m_hold = 1;
    end else begin
      m_x = nx; m_y = ny;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_x"}, BallX, 316);
    check_val({tag, "_y"}, BallY, 236);
    check_val({tag, "_dirs"}, {dir_x, dir_y}, 3);
    check_val({tag, "_flags"}, {busy, update_done, score_l, score_r, overrun}, 0);
  endtask

  task automatic do_serve();
    serve = 1'b1;
    @(posedge sys_clk); #1 serve = 1'b0;
    m_hold = 0; m_ovr = 0; m_spd = 2;
  endtask

  task automatic hold_tick();
    frame_tick = 1'b1;
    @(posedge sys_clk); #1 frame_tick = 1'b0;
    check_val("hold_busy", busy, 0);
    @(posedge sys_clk); #1;
    check_val("hold_quiet", {busy, update_done, overrun}, 0);
  endtask

  // Called #1 after a clock edge; returns one cycle after the commit edge.
  task automatic do_frame(input int lp, input int rp, input int extra_at);
    int ox, oy;
    ox = BallX; oy = BallY;
    LPadY = 9'(lp); RPadY = 9'(rp);
    frame_tick = 1'b1;
    @(posedge sys_clk); #1 frame_tick = 1'b0;
    check_val("busy_start", busy, 1);
    for (int i = 1; i <= 3; i++) begin
      if (i == extra_at) begin frame_tick = 1'b1; m_ovr = 1; end
      @(posedge sys_clk); #1 frame_tick = 1'b0;
      check_val("mid_busy_done", {busy, update_done}, 2);
      check_val("mid_pos", {BallX, BallY}, {10'(ox), 9'(oy)});
    end
    model_frame(lp, rp);
    @(posedge sys_clk); #1;
    check_val("commit_done_busy", {update_done, busy}, 2);
    check_val("commit_x", BallX, m_x);
    check_val("commit_y", BallY, m_y);
    check_val("commit_dirs", {dir_x, dir_y}, {1'(m_dx), 1'(m_dy)});
    check_val("commit_scores", {score_l, score_r}, {1'(e_sl), 1'(e_sr)});
    check_val("commit_overrun", overrun, m_ovr);
    frames++;
    $display("frame %0d: lp=%0d rp=%0d -> x=%0d y=%0d dx=%0d dy=%0d sl=%0d sr=%0d ovr=%0d",
             frames, lp, rp, BallX, BallY, dir_x, dir_y, score_l, score_r, overrun);
    @(posedge sys_clk); #1;
    check_val("pulse_end", {update_done, score_l, score_r}, 0);
  endtask

  function automatic int clamp_pad(input int v);
    if (v < 0) return 0;
    if (v > 416) return 416;
    return v;
  endfunction

  initial begin
    int lp, rp, extra;
    model_reset();
    #12;
    check_reset_vals("reset_low");
    @(posedge sys_clk); #1 reset_n = 1'b1;
    check_reset_vals("reset_rel");
    hold_tick();
    check_val("hold_pos", {BallX, BallY}, {10'd316, 9'd236});

    do_serve();
    do_frame(0, 0, 0);
    check_val("first_step_x", BallX, 318);
    check_val("first_step_y", BallY, 238);

    do_frame(0, 0, 2);
    check_val("overrun_set", overrun, 1);

    // Asynchronous reset in the middle of an update.
    frame_tick = 1'b1;
    @(posedge sys_clk); #1 frame_tick = 1'b0;
    @(posedge sys_clk); #1 reset_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    model_reset();
    @(posedge sys_clk); #1 reset_n = 1'b1;
    @(posedge sys_clk); #1;
    check_reset_vals("after_reset");

    for (int f = 0; f < 3000; f++) begin
      if (m_hold != 0) begin
        if ($urandom_range(0, 1) == 1) hold_tick();
        do_serve();
      end
      if ($urandom_range(0, 2) == 0) begin
        lp = $urandom_range(0, 416);
        rp = $urandom_range(0, 416);
      end else begin
        lp = clamp_pad(m_y - 60 + $urandom_range(0, 64));
        rp = clamp_pad(m_y - 60 + $urandom_range(0, 64));
      end
      extra = ($urandom_range(0, 39) == 0) ? $urandom_range(1, 3) : 0;
      do_frame(lp, rp, extra);
      repeat ($urandom_range(0, 2)) begin
        if (m_hold == 0 && $urandom_range(0, 7) == 0) serve = 1'b1;
        @(posedge sys_clk); #1 serve = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
